// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the 4:1 mux round-robin arbiter: sizes, FSM encoding
// and the one-hot grant helper.
package mux_ctrl_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot2(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Cyclic first-set search over four requests, starting at PTR and wrapping,
// so the requester at PTR has highest priority and PTR-1 the lowest.
module rr_pick4
  import mux_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] REQ,
  input  logic [SEL_W-1:0] PTR,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset down to 0 so the nearest set bit wins.
  always_comb begin
    idx   = PTR;
    found = 1'b0;
    cand  = PTR;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = PTR + SEL_W'(k);
      if (REQ[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of the shared 4:1 mux; holds a grant
// until the owner finishes or the hold limit expires, then rotates priority.
module mux4_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_REQ-1:0] REQ,
  input  logic             LAST,
  output logic [N_REQ-1:0] GNT,
  output logic [SEL_W-1:0] SEL,
  output logic             BUSY,
  output logic [CNT_W-1:0] HOLD_CNT
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [SEL_W-1:0] owner_next;
  logic [SEL_W-1:0] pick_ptr;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             release_w;

  assign owner_next = sel_q + SEL_W'(1);

  // On release the new pointer (owner+1) is used in the same edge, so the
  // picker is fed that value directly instead of waiting for ptr_q to update.
  assign pick_ptr  = (state_q == GRANT) ? owner_next : ptr_q;
  assign release_w = (state_q == GRANT) &&
                     (!REQ[sel_q] || LAST || (cnt_q == HOLD_LAST));

  rr_pick4 u_pick (
    .REQ   (REQ),
    .PTR   (pick_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          sel_d   = pick_idx;
          gnt_d   = onehot2(pick_idx);
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (release_w) begin
          ptr_d = owner_next;
          if (pick_found) begin
            sel_d = pick_idx;
            gnt_d = onehot2(pick_idx);
            cnt_d = '0;
          end else begin
            // SEL deliberately keeps the last owner so the mux output stays put.
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign GNT      = gnt_q;
  assign SEL      = sel_q;
  assign BUSY     = (state_q == GRANT);
  assign HOLD_CNT = cnt_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: two instances (hold limit 8 and 1)
// share stimulus; a reference model queues expectations, a monitor checks them.
module tb_mux4_rr_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [7:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       last;

  logic [3:0] gnt  [2];
  logic [1:0] sel  [2];
  logic       busy [2];
  logic [7:0] cnt  [2];

  int checks = 0;
  int fails  = 0;

  exp_t q0[$];
  exp_t q1[$];

  int m_busy [2];
  int m_sel  [2];
  int m_ptr  [2];
  int m_cnt  [2];
  int m_hold [2];

  mux4_rr_arbiter #(.MAX_HOLD(8), .CNT_W(8)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .LAST(last),
    .GNT(gnt[0]), .SEL(sel[0]), .BUSY(busy[0]), .HOLD_CNT(cnt[0])
  );

  mux4_rr_arbiter #(.MAX_HOLD(1), .CNT_W(8)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .REQ(req), .LAST(last),
    .GNT(gnt[1]), .SEL(sel[1]), .BUSY(busy[1]), .HOLD_CNT(cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: arbitration described directly from the rules.
  function automatic int search(input int ptr, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 0; m_sel[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
    end
  endtask

  task automatic model_step(input int d, input logic [3:0] r, input logic l);
    if (m_busy[d] == 0) begin
      if (r != 4'b0) begin
        m_sel[d]  = search(m_ptr[d], r);
        m_busy[d] = 1;
        m_cnt[d]  = 0;
      end
    end else if (r[m_sel[d]] == 1'b0 || l || m_cnt[d] == m_hold[d] - 1) begin
      m_ptr[d] = (m_sel[d] + 1) % 4;
      if (r != 4'b0) begin
        m_sel[d] = search(m_ptr[d], r);
        m_cnt[d] = 0;
      end else begin
        m_busy[d] = 0;
        m_cnt[d]  = 0;
      end
    end else begin
      m_cnt[d] = m_cnt[d] + 1;
    end
  endtask

  function automatic exp_t expected(input int d);
    exp_t e;
    e.gnt  = (m_busy[d] != 0) ? 4'(1 << m_sel[d]) : 4'b0;
    e.sel  = 2'(m_sel[d]);
    e.busy = (m_busy[d] != 0);
    e.cnt  = 8'(m_cnt[d]);
    return e;
  endfunction

  // One clock of stimulus; expectations describe the state after the next edge.
  task automatic step(input logic [3:0] r, input logic l);
    @(negedge clk);
    req  = r;
    last = l;
    for (int d = 0; d < 2; d++) model_step(d, r, l);
    q0.push_back(expected(0));
    q1.push_back(expected(1));
  endtask

  task automatic compare(input int d, input exp_t e);
    exp_t act;
    logic inv_ok;
    act = {gnt[d], sel[d], busy[d], cnt[d]};
    checks++;
    if (act !== e) begin
      fails++;
      $display("FAIL dut%0d outputs t=%0t: got gnt=%b sel=%0d busy=%b cnt=%0d, need gnt=%b sel=%0d busy=%b cnt=%0d",
               d, $time, act.gnt, act.sel, act.busy, act.cnt, e.gnt, e.sel, e.busy, e.cnt);
    end
    inv_ok = ((gnt[d] == 4'b0) || $onehot(gnt[d])) && (busy[d] == (|gnt[d])) &&
             (!busy[d] || gnt[d][sel[d]]);
    checks++;
    if (inv_ok !== 1'b1) begin
      fails++;
      $display("FAIL dut%0d invariant t=%0t: got gnt=%b sel=%0d busy=%b, need one-hot/zero gnt with gnt[sel]==busy",
               d, $time, gnt[d], sel[d], busy[d]);
    end
  endtask

  task automatic check_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (gnt[d] !== 4'b0 || sel[d] !== 2'd0 || busy[d] !== 1'b0 || cnt[d] !== 8'd0) begin
        fails++;
        $display("FAIL dut%0d %s: got gnt=%b sel=%0d busy=%b cnt=%0d, need all zero",
                 name.len() > 0 ? d : d, name, gnt[d], sel[d], busy[d], cnt[d]);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0;
    last  = 1'b0;
    #1 check_zero("reset");
    repeat (3) begin
      @(negedge clk);
      check_zero("reset_hold");
    end
    model_reset();
    rst_n = 1'b1;
  endtask

  // Monitor: compares queued expectations shortly after each active edge.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (q0.size() > 0) compare(0, q0.pop_front());
      if (q1.size() > 0) compare(1, q1.pop_front());
    end
  end

  initial begin
    int guard;
    logic [3:0] r;
    m_hold[0] = 8;
    m_hold[1] = 1;
    model_reset();
    rst_n = 1'b0;
    req   = 4'b0;
    last  = 1'b0;

    do_reset();
    repeat (5) step(4'b0000, 1'b0);
    repeat (20) step(4'b0100, 1'b0);

    do_reset();
    repeat (20) step(4'b1111, 1'b0);

    // Early release by LAST, then owner drop with wrap-around search.
    do_reset();
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b1);
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b0);
    step(4'b0001, 1'b0);
    step(4'b0001, 1'b0);

    // Return to idle with SEL parked on the last owner.
    do_reset();
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b0000, 1'b0);
    step(4'b1001, 1'b0);
    step(4'b1001, 1'b0);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    guard = 0;
    do begin
      step(4'b0001, 1'b0);
      guard++;
    end while (!(m_busy[0] != 0 && m_cnt[0] == 5) && guard < 20);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1 check_zero("midgrant_reset");
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    step(4'b1000, 1'b0);
    step(4'b1000, 1'b0);

    // Randomized traffic.
    r = 4'($urandom_range(0, 15));
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r, ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    if (q0.size() != 0 || q1.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: got %0d/%0d pending, need 0/0", q0.size(), q1.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
